// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - memory-mapped transmit FIFO with drain interrupt (optional MMIO_TX_LOWWATER_EN)
// Word window at BASE: +0 DATA (push), +4 STATUS (read), +8 CTRL (irq enable / ack / low-water).
module mmio_tx_fifo #(
  parameter int          DEPTH = 8,
  parameter int          PTR_W = 3,
  parameter logic [31:0] BASE  = 32'hFFFF0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        io_sel,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        tx_irq
);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]      ADDR_DATA   = BASE;
  localparam logic [31:0]      ADDR_STATUS = BASE + 32'd4;
  localparam logic [31:0]      ADDR_CTRL   = BASE + 32'd8;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             irq_en_q, irq_en_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             tx_irq_q;

  logic sel_data, sel_status, sel_ctrl;
  logic full, empty;
  logic push_req, do_push, pop, ovf_evt;
  logic ctrl_wr, ack, drain, pend_set;
  logic [31:0] status;

  assign sel_data   = (addr == ADDR_DATA);
  assign sel_status = (addr == ADDR_STATUS);
  assign sel_ctrl   = (addr == ADDR_CTRL);
  assign io_sel     = sel_data | sel_status | sel_ctrl;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  assign tx_data  = mem_q[head_q];
  assign tx_irq   = tx_irq_q;

  // A pop at full frees the slot the simultaneous push lands in.
  assign push_req = sel_data & mem_write;
  assign pop      = tx_valid & tx_ready;
  assign do_push  = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;

  assign ctrl_wr = sel_ctrl & mem_write;
  assign ack     = ctrl_wr & wr_data[1];
  assign drain   = pop & ~push_req & (count_q == CNT_ONE);

`ifdef MMIO_TX_LOWWATER_EN
  logic [PTR_W:0] lw_q, lw_d;
  logic           lw_evt;

  // Pop without push always lowers count, so LW < count-before holds whenever this matches.
  assign lw_evt   = pop & ~push_req & ((count_q - CNT_ONE) == lw_q);
  assign pend_set = drain | lw_evt;

  always_comb begin
    lw_d = lw_q;
    if (ctrl_wr) lw_d = wr_data[PTR_W+8:8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lw_q <= '0;
    else        lw_q <= lw_d;
  end
`else
  assign pend_set = drain;
`endif

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (pop)     head_d = head_q + PTR_ONE;
    if (do_push) tail_d = tail_q + PTR_ONE;

    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (ctrl_wr) irq_en_d = wr_data[0];
    if (ack) begin
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end
    if (pend_set) pending_d  = 1'b1;
    if (ovf_evt)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      tx_irq_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      tx_irq_q   <= pending_q & irq_en_q;
    end
  end

  // Storage is not reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wr_data;
  end

  always_comb begin
    status             = '0;
    status[31]         = overflow_q;
    status[30]         = pending_q;
    status[29]         = irq_en_q;
    status[17]         = empty;
    status[16]         = full;
    status[PTR_W:0]    = count_q;
`ifdef MMIO_TX_LOWWATER_EN
    status[PTR_W+24:24] = lw_q;
`endif
  end

  assign rd_data = (mem_read & sel_status) ? status : 32'h0;

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// tb/tb_mmio_tx_fifo.sv - self-checking bench for mmio_tx_fifo against a queue-based model
module tb_mmio_tx_fifo;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] rd_data;
  logic        io_sel;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        tx_irq;

  mmio_tx_fifo #(.DEPTH(DEPTH), .PTR_W(3), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data),
    .io_sel(io_sel), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          m_ovf, m_pend, m_en, m_irq;
  logic [31:0] dut_last;
  bit          seen_dead;

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[31] = m_ovf;
    s[30] = m_pend;
    s[29] = m_en;
    s[17] = (q.size() == 0);
    s[16] = (q.size() == DEPTH);
    s[3:0] = 4'(q.size());
    return s;
  endfunction

  function automatic logic m_sel(input logic [31:0] a);
    return (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8);
  endfunction

  task automatic m_clear();
    q.delete();
    m_ovf = 0; m_pend = 0; m_en = 0; m_irq = 0;
  endtask

  // One bus cycle: check outputs against the model, clock, then advance the model.
  task automatic cyc(input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic rdy);
    int  sz;
    bit  pop, push, ack, drain, new_irq;
    addr = a; mem_read = r; mem_write = w; wr_data = d; tx_ready = rdy;
    #1;
    chk("io_sel", 32'(io_sel), 32'(m_sel(a)));
    chk("rd_data", rd_data, (r && a == BASE + 32'd4) ? m_status() : 32'h0);
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk("tx_irq", 32'(tx_irq), 32'(m_irq));
    if (tx_valid && rdy) begin
      dut_last = tx_data;
      if (tx_data == 32'hDEAD) seen_dead = 1;
    end
    @(posedge clk);
    sz      = q.size();
    pop     = rdy && sz > 0;
    push    = w && a == BASE;
    ack     = w && a == BASE + 32'd8 && d[1];
    drain   = pop && sz == 1 && !push;
    new_irq = m_pend && m_en;
    if (ack) begin m_ovf = 0; m_pend = 0; end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(d);
      else m_ovf = 1;
    end
    if (drain) m_pend = 1;
    if (w && a == BASE + 32'd8) m_en = d[0];
    m_irq = new_irq;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(32'h0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  logic [31:0] pool[8];

  initial begin
    m_clear();
    dut_last = 32'h0;
    seen_dead = 0;

    // Reset with idle bus, release away from a clock edge.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_irq", 32'(tx_irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Address decode table in the reset state.
    tbl[0] = '{BASE,               1'b1, 1'b1, 32'h0};
    tbl[1] = '{BASE + 32'd4,       1'b1, 1'b1, 32'h0002_0000};
    tbl[2] = '{BASE + 32'd8,       1'b1, 1'b1, 32'h0};
    tbl[3] = '{BASE + 32'd4,       1'b0, 1'b1, 32'h0};
    tbl[4] = '{BASE + 32'd5,       1'b1, 1'b0, 32'h0};
    tbl[5] = '{BASE + 32'd12,      1'b1, 1'b0, 32'h0};
    tbl[6] = '{32'hFFFF_000C,      1'b1, 1'b0, 32'h0};
    tbl[7] = '{32'h0000_0014,      1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      addr = tbl[i].a; mem_read = tbl[i].r; mem_write = 1'b0; tx_ready = 1'b0;
      #1;
      chk($sformatf("tbl%0d_io_sel", i), 32'(io_sel), 32'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].exp_rd);
      @(posedge clk);
      #1;
    end

    // Three stores held, then drained in order.
    cyc(BASE, 1'b0, 1'b1, 32'h11, 1'b0);
    cyc(BASE, 1'b0, 1'b1, 32'h22, 1'b0);
    cyc(BASE, 1'b0, 1'b1, 32'h33, 1'b0);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("seq3_count", rd_data & 32'h0003_000F, 32'h0000_0003);
    chk("seq3_head", tx_data, 32'h11);
    idle(1'b1); chk("seq3_out0", dut_last, 32'h11);
    idle(1'b1); chk("seq3_out1", dut_last, 32'h22);
    idle(1'b1); chk("seq3_out2", dut_last, 32'h33);

    // Overflow: ninth store dropped.
    cyc(BASE + 32'd8, 1'b0, 1'b1, 32'h2, 1'b0);
    for (int i = 0; i < 8; i++) cyc(BASE, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    cyc(BASE, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("ovf_status", rd_data, 32'h8001_0008);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("ovf_last", dut_last, 32'h107);
    chk("ovf_dead_dropped", 32'(seen_dead), 32'h0);

    // Drain interrupt and acknowledge.
    cyc(BASE + 32'd8, 1'b0, 1'b1, 32'h3, 1'b0);
    cyc(BASE, 1'b0, 1'b1, 32'hA5, 1'b0);
    idle(1'b1);
    chk("irq_lat0", 32'(tx_irq), 32'h0);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("irq_pending_status", rd_data & 32'hE000_0000, 32'h6000_0000);
    chk("irq_asserted", 32'(tx_irq), 32'h1);
    cyc(BASE + 32'd8, 1'b0, 1'b1, 32'h3, 1'b0);
    chk("irq_hold_on_ack", 32'(tx_irq), 32'h1);
    idle(1'b0);
    chk("irq_cleared", 32'(tx_irq), 32'h0);

    // Push and pop on the same edge while full.
    for (int i = 0; i < 8; i++) cyc(BASE, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
    cyc(BASE, 1'b0, 1'b1, 32'h55, 1'b1);
    cyc(BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fullpp_status", rd_data & 32'h8003_000F, 32'h0001_0008);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("fullpp_last", dut_last, 32'h55);

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) cyc(BASE, 1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
    addr = BASE + 32'd4; mem_read = 1'b1; mem_write = 1'b0; tx_ready = 1'b0;
    #1;
    chk("pre_arst_count", rd_data & 32'hF, 32'h5);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_status", rd_data, 32'h0002_0000);
    chk("arst_tx_irq", 32'(tx_irq), 32'h0);
    m_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    pool[0] = BASE; pool[1] = BASE; pool[2] = BASE; pool[3] = BASE + 32'd4;
    pool[4] = BASE + 32'd8; pool[5] = BASE + 32'd2; pool[6] = BASE + 32'd12;
    pool[7] = 32'h1000_0000;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, d;
      a = pool[$urandom_range(0, 7)];
      d = $urandom;
      if (a == BASE + 32'd8 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      cyc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), d,
          1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
